// File: rtl/reg_file_pkg.sv
// Shared constants for the parameterized register file and its busy scoreboard.
package reg_file_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_BUSY_W = 2 ** DEF_ADDR_W;

    // One busy bit per register, so the vector is as wide as the array is deep.
    function automatic int busyVecW(input int addrW);
        return 2 ** addrW;
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Busy-register scoreboard: reservation sets a bit, writeback clears it; keeps a
// running population count and flags reservations of already-busy registers.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] selD,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] selR,
    input  logic [ADDR_W-1:0] selA,
    input  logic [ADDR_W-1:0] selB,
    output logic              busyA,
    output logic              busyB,
    output logic [ADDR_W:0]   busyCnt,
    output logic              rsvErr
);

    localparam int BUSY_W = busyVecW(ADDR_W);

    logic [BUSY_W-1:0] busy, busyNxt;
    logic              wrClr, rsvSet, inc, dec, err;

    always_comb begin
        wrClr   = en && we  && !((ZERO_REG != 0) && (selD == '0));
        rsvSet  = en && rsv && !((ZERO_REG != 0) && (selR == '0));
        busyNxt = busy;
        if (wrClr)  busyNxt[selD] = 1'b0;
        // Reservation applied last so it wins over a same-register writeback.
        if (rsvSet) busyNxt[selR] = 1'b1;
        inc = rsvSet && !busy[selR];
        dec = wrClr && busy[selD] && !(rsvSet && (selR == selD));
        err = rsvSet && busy[selR] && !(wrClr && (selD == selR));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= '0;
            busyCnt <= '0;
            busyA   <= 1'b0;
            busyB   <= 1'b0;
            rsvErr  <= 1'b0;
        end else if (en) begin
            busy    <= busyNxt;
            busyCnt <= busyCnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
            busyA   <= busyNxt[selA];
            busyB   <= busyNxt[selB];
            rsvErr  <= err;
        end
    end

endmodule

// File: rtl/reg_file_param.sv
// Parameterized 2-read/1-write register file with registered reads, optional
// write-to-read bypass, optional hardwired-zero r0 and a busy scoreboard.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_en,
    input  logic              I_we,
    input  logic [ADDR_W-1:0] I_selA,
    input  logic [ADDR_W-1:0] I_selB,
    input  logic [ADDR_W-1:0] I_selD,
    input  logic [DATA_W-1:0] I_dataD,
    input  logic              I_rsv,
    input  logic [ADDR_W-1:0] I_selR,
    output logic [DATA_W-1:0] o_dataA,
    output logic [DATA_W-1:0] o_dataB,
    output logic              o_busyA,
    output logic              o_busyB,
    output logic [ADDR_W:0]   o_busy_cnt,
    output logic              o_rsv_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdA, rdB;
    logic              wrEn;

    always_comb begin
        wrEn = I_en && I_we && !((ZERO_REG != 0) && (I_selD == '0));
        rdA  = mem[I_selA];
        rdB  = mem[I_selB];
        if ((BYPASS != 0) && wrEn && (I_selD == I_selA)) rdA = I_dataD;
        if ((BYPASS != 0) && wrEn && (I_selD == I_selB)) rdB = I_dataD;
        // r0 never holds data in zero-register mode, so mask after the bypass mux.
        if ((ZERO_REG != 0) && (I_selA == '0)) rdA = '0;
        if ((ZERO_REG != 0) && (I_selB == '0)) rdB = '0;
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            o_dataA <= '0;
            o_dataB <= '0;
        end else if (I_en) begin
            if (wrEn) mem[I_selD] <= I_dataD;
            o_dataA <= rdA;
            o_dataB <= rdB;
        end
    end

    reg_file_scoreboard #(
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) uScoreboard (
        .clk    (I_clk),
        .rst    (I_rst),
        .en     (I_en),
        .we     (I_we),
        .selD   (I_selD),
        .rsv    (I_rsv),
        .selR   (I_selR),
        .selA   (I_selA),
        .selB   (I_selB),
        .busyA  (o_busyA),
        .busyB  (o_busyB),
        .busyCnt(o_busy_cnt),
        .rsvErr (o_rsv_err)
    );

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: three configurations share one stimulus
// stream; expectations are queued by the driver and checked by a monitor.
module tb_reg_file_param;

    localparam int NI = 3;  // 0: default, 1: BYPASS=0, 2: ZERO_REG=1
    localparam int F_DA = 0, F_DB = 1, F_BA = 2, F_BB = 3, F_CNT = 4, F_ERR = 5;

    logic        I_clk = 1'b0, I_rst, I_en, I_we, I_rsv;
    logic [2:0]  I_selA, I_selB, I_selD, I_selR;
    logic [15:0] I_dataD;

    logic [15:0] dA [NI];
    logic [15:0] dB [NI];
    logic        bA [NI];
    logic        bB [NI];
    logic [3:0]  cnt [NI];
    logic        err [NI];

    typedef struct {
        int          cyc;
        int          inst;
        int          fld;
        logic [15:0] val;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   nChk = 0, nFail = 0;
    event chkNow;

    always #5 I_clk = ~I_clk;
    always @(posedge I_clk) cyc <= cyc + 1;

    reg_file_param #(.ZERO_REG(0), .BYPASS(1)) u0 (
        .I_clk(I_clk), .I_rst(I_rst), .I_en(I_en), .I_we(I_we),
        .I_selA(I_selA), .I_selB(I_selB), .I_selD(I_selD), .I_dataD(I_dataD),
        .I_rsv(I_rsv), .I_selR(I_selR), .o_dataA(dA[0]), .o_dataB(dB[0]),
        .o_busyA(bA[0]), .o_busyB(bB[0]), .o_busy_cnt(cnt[0]), .o_rsv_err(err[0]));
    reg_file_param #(.ZERO_REG(0), .BYPASS(0)) u1 (
        .I_clk(I_clk), .I_rst(I_rst), .I_en(I_en), .I_we(I_we),
        .I_selA(I_selA), .I_selB(I_selB), .I_selD(I_selD), .I_dataD(I_dataD),
        .I_rsv(I_rsv), .I_selR(I_selR), .o_dataA(dA[1]), .o_dataB(dB[1]),
        .o_busyA(bA[1]), .o_busyB(bB[1]), .o_busy_cnt(cnt[1]), .o_rsv_err(err[1]));
    reg_file_param #(.ZERO_REG(1), .BYPASS(1)) u2 (
        .I_clk(I_clk), .I_rst(I_rst), .I_en(I_en), .I_we(I_we),
        .I_selA(I_selA), .I_selB(I_selB), .I_selD(I_selD), .I_dataD(I_dataD),
        .I_rsv(I_rsv), .I_selR(I_selR), .o_dataA(dA[2]), .o_dataB(dB[2]),
        .o_busyA(bA[2]), .o_busyB(bB[2]), .o_busy_cnt(cnt[2]), .o_rsv_err(err[2]));

    function automatic logic [15:0] act(input int i, input int f);
        case (f)
            F_DA:    return dA[i];
            F_DB:    return dB[i];
            F_BA:    return {15'd0, bA[i]};
            F_BB:    return {15'd0, bB[i]};
            F_CNT:   return {12'd0, cnt[i]};
            default: return {15'd0, err[i]};
        endcase
    endfunction

    // Monitor: pops every expectation due at this sample point.
    initial begin
        exp_t e;
        logic [15:0] a;
        forever begin
            @(negedge I_clk or chkNow);
            while (q.size() > 0 && (q[0].cyc < 0 || q[0].cyc <= cyc)) begin
                e = q.pop_front();
                nChk++;
                if (e.cyc >= 0 && e.cyc < cyc) begin
                    nFail++;
                    $display("FAIL %s u%0d: expectation for cycle %0d not sampled (now %0d)",
                             e.nm, e.inst, e.cyc, cyc);
                end else begin
                    a = act(e.inst, e.fld);
                    if (a !== e.val) begin
                        nFail++;
                        $display("FAIL %s u%0d: got %h expected %h", e.nm, e.inst, a, e.val);
                    end
                end
            end
        end
    end

    task automatic ex(input int i, input int f, input logic [15:0] v, input string nm);
        exp_t e;
        e.cyc = cyc + 1; e.inst = i; e.fld = f; e.val = v; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic exNow(input int i, input int f, input logic [15:0] v, input string nm);
        exp_t e;
        e.cyc = -1; e.inst = i; e.fld = f; e.val = v; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic drive(input logic en, input logic we, input logic [2:0] sd,
                         input logic [15:0] d, input logic rsv, input logic [2:0] sr,
                         input logic [2:0] sa, input logic [2:0] sb);
        I_en = en; I_we = we; I_selD = sd; I_dataD = d;
        I_rsv = rsv; I_selR = sr; I_selA = sa; I_selB = sb;
    endtask

    task automatic tick();
        @(negedge I_clk);
        #1;
    endtask

    task automatic resetChecks(input string nm);
        for (int i = 0; i < NI; i++) begin
            exNow(i, F_DA, 16'h0, nm); exNow(i, F_DB, 16'h0, nm);
            exNow(i, F_BA, 16'h0, nm); exNow(i, F_BB, 16'h0, nm);
            exNow(i, F_CNT, 16'h0, nm); exNow(i, F_ERR, 16'h0, nm);
        end
        ->chkNow;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        I_rst = 1'b1;
        drive(1, 0, 0, 16'h0, 0, 0, 0, 1);
        tick(); tick();
        resetChecks("reset");
        I_rst = 1'b0;

        // Write r0 while reading r0/r1: bypass vs. registered old value vs. zero reg.
        drive(1, 1, 0, 16'hFFFF, 0, 0, 0, 1);
        ex(0, F_DA, 16'hFFFF, "byp_wr_r0"); ex(0, F_DB, 16'h0, "byp_rd_r1");
        ex(1, F_DA, 16'h0, "nobyp_prior"); ex(2, F_DA, 16'h0, "zero_r0");
        tick();
        drive(1, 0, 0, 16'h0, 0, 0, 0, 1);
        ex(1, F_DA, 16'hFFFF, "nobyp_late"); ex(0, F_DA, 16'hFFFF, "r0_kept");
        ex(2, F_DA, 16'h0, "zero_r0_again");
        tick();

        // Back-to-back writes to r2, then a disabled write to r0.
        drive(1, 1, 2, 16'h2222, 0, 0, 2, 0);
        ex(0, F_DA, 16'h2222, "r2_first"); ex(1, F_DA, 16'h0, "r2_first_nobyp");
        tick();
        drive(1, 1, 2, 16'h3333, 0, 0, 2, 0);
        ex(0, F_DA, 16'h3333, "r2_second"); ex(1, F_DA, 16'h2222, "r2_second_nobyp");
        tick();
        drive(1, 0, 0, 16'hFEED, 0, 0, 2, 0);
        ex(0, F_DA, 16'h3333, "r2_last"); ex(0, F_DB, 16'hFFFF, "r0_no_we");
        ex(1, F_DA, 16'h3333, "r2_last_nobyp"); ex(2, F_DB, 16'h0, "zero_r0_b");
        tick();

        // Write + reserve r0: zero reg drops both; others take reservation and data.
        drive(1, 1, 0, 16'hBEEF, 1, 0, 0, 0);
        ex(2, F_DA, 16'h0, "z_data"); ex(2, F_BA, 16'h0, "z_busy");
        ex(2, F_CNT, 16'h0, "z_cnt"); ex(2, F_ERR, 16'h0, "z_err");
        ex(0, F_DA, 16'hBEEF, "r0_wr_rsv_data"); ex(0, F_BA, 16'h1, "r0_rsv_wins");
        ex(0, F_CNT, 16'h1, "r0_rsv_cnt");
        tick();

        // Reserve r4, r5, then r4 again (error pulse), then write r4.
        drive(1, 0, 0, 16'h0, 1, 4, 4, 0);
        ex(2, F_BA, 16'h1, "r4_busy"); ex(2, F_CNT, 16'h1, "cnt_r4");
        ex(0, F_CNT, 16'h2, "cnt_r4_u0");
        tick();
        drive(1, 0, 0, 16'h0, 1, 5, 4, 5);
        ex(2, F_BB, 16'h1, "r5_busy"); ex(2, F_CNT, 16'h2, "cnt_r5");
        ex(0, F_CNT, 16'h3, "cnt_r5_u0"); ex(2, F_ERR, 16'h0, "no_err");
        tick();
        drive(1, 0, 0, 16'h0, 1, 4, 4, 5);
        ex(2, F_ERR, 16'h1, "rsv_err"); ex(2, F_CNT, 16'h2, "err_cnt_hold");
        ex(0, F_ERR, 16'h1, "rsv_err_u0"); ex(0, F_CNT, 16'h3, "err_cnt_u0");
        tick();
        drive(1, 0, 0, 16'h0, 0, 0, 4, 5);
        ex(2, F_ERR, 16'h0, "err_one_cycle"); ex(2, F_CNT, 16'h2, "cnt_idle");
        tick();
        drive(1, 1, 4, 16'h4444, 0, 0, 4, 5);
        ex(2, F_CNT, 16'h1, "wb_cnt"); ex(2, F_BA, 16'h0, "wb_clear");
        ex(2, F_DA, 16'h4444, "wb_data"); ex(1, F_DA, 16'h0, "wb_data_nobyp");
        ex(1, F_BA, 16'h0, "wb_clear_u1"); ex(0, F_CNT, 16'h2, "wb_cnt_u0");
        tick();
        drive(1, 0, 0, 16'h0, 0, 0, 4, 5);
        ex(1, F_DA, 16'h4444, "wb_late_nobyp"); ex(2, F_BB, 16'h1, "r5_still_busy");
        tick();

        // Same-edge write and reserve of r3.
        drive(1, 1, 3, 16'h3A3A, 1, 3, 3, 5);
        ex(2, F_BA, 16'h1, "r3_busy"); ex(2, F_CNT, 16'h2, "r3_cnt");
        ex(2, F_DA, 16'h3A3A, "r3_data"); ex(2, F_ERR, 16'h0, "r3_no_err");
        ex(0, F_CNT, 16'h3, "r3_cnt_u0");
        tick();

        // Disabled for three cycles with write and reserve asserted: everything holds.
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 6, 16'h1111, 1, 6, 6, 3);
            ex(2, F_DA, 16'h3A3A, "hold_data"); ex(2, F_BA, 16'h1, "hold_busy");
            ex(2, F_CNT, 16'h2, "hold_cnt"); ex(0, F_CNT, 16'h3, "hold_cnt_u0");
            tick();
        end
        drive(1, 0, 0, 16'h0, 0, 0, 6, 3);
        ex(2, F_DA, 16'h0, "r6_untouched"); ex(2, F_BA, 16'h0, "r6_not_busy");
        ex(2, F_CNT, 16'h2, "cnt_after_hold"); ex(2, F_DB, 16'h3A3A, "r3_kept");
        tick();

        // Both read ports on the register being written.
        drive(1, 1, 7, 16'h7777, 0, 0, 7, 7);
        ex(0, F_DA, 16'h7777, "dual_byp_a"); ex(0, F_DB, 16'h7777, "dual_byp_b");
        ex(1, F_DA, 16'h0, "dual_nobyp_a"); ex(1, F_DB, 16'h0, "dual_nobyp_b");
        tick();

        // Asynchronous reset between edges with a write and reservation in flight.
        drive(1, 0, 0, 16'h0, 0, 0, 4, 5);
        ex(2, F_DA, 16'h4444, "pre_rst_r4"); ex(2, F_BB, 16'h1, "pre_rst_r5");
        ex(2, F_CNT, 16'h2, "pre_rst_cnt");
        tick();
        drive(1, 1, 4, 16'h9999, 1, 6, 4, 5);
        #2;
        I_rst = 1'b1;
        #1;
        resetChecks("async_rst");
        tick();
        resetChecks("rst_held");
        I_rst = 1'b0;
        drive(1, 0, 0, 16'h0, 0, 0, 4, 5);
        for (int i = 0; i < NI; i++) begin
            ex(i, F_DA, 16'h0, "post_rst_r4"); ex(i, F_BB, 16'h0, "post_rst_r5");
            ex(i, F_CNT, 16'h0, "post_rst_cnt");
        end
        tick();
        tick();

        if (q.size() != 0) begin
            nChk++;
            nFail++;
            $display("FAIL leftover: %0d expectations never sampled, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
